// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: scan FSM states, segment patterns and the BCD decoder.
// Patterns are active-high {g,f,e,d,c,b,a}; the scanner applies output polarity.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // Codes 10..15 are not decimal digits and show a dash so bad data is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] pattern;
    pattern = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) pattern = SEG_DIGIT[i];
    end
    return pattern;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Down-counting prescaler: counts DIV-1 -> 0 and reloads; o_tick is high while the count is 0.
// i_hold parks the counter at its reload value and suppresses the tick.
module tick_divider #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_hold,
  output logic o_tick
);

  localparam int                CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RELOAD;
    end else if (i_hold || (r_count == '0)) begin
      r_count <= RELOAD;
    end else begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tick = (r_count == '0) && !i_hold;

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexes a packed BCD digit bus onto a common-anode seven-segment bank.
// Digits are snapshotted once per frame; each slot is one blanking cycle followed by the lit digit.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   digits_bcd,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF  = SEG_BLANK ^ SEG_POL;
  localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};

  scan_state_t             r_state;
  scan_state_t             w_state_nxt;
  logic [IDX_W-1:0]        r_index;
  logic [DIGITS-1:0][3:0]  r_snapshot;
  logic [6:0]              r_seg;
  logic [DIGITS-1:0]       r_an;
  logic                    r_frame_done;

  logic                    w_hold;
  logic                    w_tick;
  logic                    w_start;
  logic                    w_advance;
  logic                    w_wrap;
  logic [DIGITS-1:0]       w_dark;
  logic [6:0]              w_seg_nxt;
  logic [DIGITS-1:0]       w_an_nxt;

  assign w_hold    = (r_state == ST_IDLE);
  assign w_start   = (r_state == ST_IDLE) && enable;
  assign w_advance = (r_state == ST_SHOW) && w_tick && enable;
  assign w_wrap    = w_advance && (r_index == LAST_IDX);

  tick_divider #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (reset),
    .i_hold (w_hold),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  w_state_nxt = ST_BLANK;
        ST_BLANK: w_state_nxt = ST_SHOW;
        ST_SHOW:  if (w_tick) w_state_nxt = ST_BLANK;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // A digit above 0 goes dark while it and every more significant digit are zero.
  always_comb begin : p_lead_zero
    logic nz_above;
    nz_above = 1'b0;
    w_dark   = '0;
    for (int k = DIGITS - 1; k > 0; k--) begin
      nz_above  = nz_above | (r_snapshot[k] != 4'd0);
      w_dark[k] = BLANK_LEADING && !nz_above;
    end
  end

  always_comb begin
    w_seg_nxt = SEG_OFF;
    w_an_nxt  = AN_OFF;
    if (enable && (r_state == ST_SHOW)) begin
      w_an_nxt = AN_OFF ^ (DIGITS'(1) << r_index);
      if (!w_dark[r_index]) w_seg_nxt = bcd_to_seg(r_snapshot[r_index]) ^ SEG_POL;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_index      <= '0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset like any other register.
      r_snapshot   <= '0;
      r_seg        <= SEG_OFF;
      r_an         <= AN_OFF;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_wrap;
      if (w_start) begin
        r_index <= '0;
      end else if (w_advance) begin
        r_index <= w_wrap ? '0 : r_index + 1'b1;
      end
      if (w_start || w_wrap) r_snapshot <= digits_bcd;
    end
  end

  assign seg        = r_seg;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, 4-cycle slots, active-low outputs).
// A second instance with leading-zero blanking disabled runs on the same inputs.
module tb_seven_seg_scanner;

  typedef struct {
    logic [15:0]      bcd;
    logic [3:0][6:0]  seg;     // expected seg per slot, [3] = most significant digit
    logic [3:0][6:0]  seg_nb;  // same, for the instance without leading-zero blanking
  } vec_t;

  localparam logic [6:0] OFF = 7'h7F;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [15:0] digits_bcd;
  logic [6:0]  seg,    seg_nb;
  logic [3:0]  an,     an_nb;
  logic        frame_done, frame_done_nb;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs [6];

  seven_seg_scanner #(
    .DIGITS (4), .REFRESH_DIV (4), .BLANK_LEADING (1'b1), .ACTIVE_LOW (1'b1)
  ) u_dut (
    .clk (clk), .reset (reset), .enable (enable), .digits_bcd (digits_bcd),
    .seg (seg), .an (an), .frame_done (frame_done)
  );

  seven_seg_scanner #(
    .DIGITS (4), .REFRESH_DIV (4), .BLANK_LEADING (1'b0), .ACTIVE_LOW (1'b1)
  ) u_dut_nb (
    .clk (clk), .reset (reset), .enable (enable), .digits_bcd (digits_bcd),
    .seg (seg_nb), .an (an_nb), .frame_done (frame_done_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_dark(input string name);
    check({name, " main"}, {20'd0, seg, an, frame_done},          {20'd0, OFF, 4'hF, 1'b0});
    check({name, " nb"},   {20'd0, seg_nb, an_nb, frame_done_nb}, {20'd0, OFF, 4'hF, 1'b0});
  endtask

  function automatic vec_t mk(input logic [15:0] bcd, input logic [3:0][6:0] s,
                              input logic [3:0][6:0] s_nb);
    vec_t v;
    v.bcd    = bcd;
    v.seg    = s;
    v.seg_nb = s_nb;
    return v;
  endfunction

  // Expected {seg, an, frame_done} n cycles after the edge that sees enable rise from idle.
  // Cycle 0 is the idle-derived output, then slots of 1 dark + 3 lit cycles, 16 cycles per frame.
  function automatic logic [11:0] exp_out(input vec_t a, input vec_t b, input int n,
                                          input int drop_n, input bit nb);
    logic [6:0] s;
    logic [3:0] anv;
    logic       fd;
    int         m;
    int         slot;
    vec_t       v;
    s   = OFF;
    anv = 4'hF;
    fd  = 1'b0;
    if (n >= 1 && !(drop_n >= 0 && n > drop_n)) begin
      m  = n - 1;
      fd = ((m % 16) == 15);
      if ((m % 4) != 0) begin
        slot = (m / 4) % 4;
        v    = ((m / 16) == 0) ? a : b;
        s    = nb ? v.seg_nb[slot] : v.seg[slot];
        anv  = ~(4'b0001 << slot);
      end
    end
    return {s, anv, fd};
  endfunction

  // Starts a scan from idle with a's digits; b's digits go in at cycle chg_n, enable drops at drop_n.
  task automatic run_scan(input string tag, input vec_t a, input vec_t b,
                          input int chg_n, input int drop_n, input int ncyc);
    digits_bcd = a.bcd;
    enable     = 1'b1;
    for (int n = 0; n < ncyc; n++) begin
      step();
      check($sformatf("%s n=%0d", tag, n), {20'd0, seg, an, frame_done},
            {20'd0, exp_out(a, b, n, drop_n, 1'b0)});
      check($sformatf("%s nb n=%0d", tag, n), {20'd0, seg_nb, an_nb, frame_done_nb},
            {20'd0, exp_out(a, b, n, drop_n, 1'b1)});
      if (n == chg_n)  digits_bcd = b.bcd;
      if (n == drop_n) enable = 1'b0;
    end
  endtask

  task automatic go_idle(input string tag);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_dark($sformatf("%s idle %0d", tag, i));
    end
  endtask

  initial begin
    // Segment codes (active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 dash=3F dark=7F
    vecs[0] = mk(16'h1234, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19});
    vecs[1] = mk(16'h0050, {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h40, 7'h40, 7'h12, 7'h40});
    vecs[2] = mk(16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40});
    vecs[3] = mk(16'h00A0, {7'h7F, 7'h7F, 7'h3F, 7'h40}, {7'h40, 7'h40, 7'h3F, 7'h40});
    vecs[4] = mk(16'h8000, {7'h00, 7'h40, 7'h40, 7'h40}, {7'h00, 7'h40, 7'h40, 7'h40});
    vecs[5] = mk(16'h9876, {7'h10, 7'h00, 7'h78, 7'h02}, {7'h10, 7'h00, 7'h78, 7'h02});

    reset      = 1'b0;
    enable     = 1'b0;
    digits_bcd = 16'h0000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check_dark($sformatf("in_reset %0d", i));
      step();
    end
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      check_dark($sformatf("idle_disabled %0d", i));
    end

    // Two full frames per vector: slot order, blanking cycles, leading zeros, frame_done at 16 and 32.
    for (int i = 0; i < 6; i++) begin
      go_idle($sformatf("pre_vec%0d", i));
      run_scan($sformatf("vec %h", vecs[i].bcd), vecs[i], vecs[i], -1, -1, 34);
    end

    // Input change mid-frame is only picked up at the frame wrap.
    go_idle("pre_change");
    run_scan("change", vecs[0], vecs[5], 8, -1, 34);

    // enable dropped while digit 0 is lit, then a clean restart from digit 0.
    go_idle("pre_drop");
    run_scan("drop_show", vecs[0], vecs[0], -1, 2, 8);
    run_scan("restart_show", vecs[5], vecs[5], -1, -1, 20);

    // enable dropped on the wrap edge: no frame_done, then restart.
    go_idle("pre_wrapdrop");
    run_scan("drop_wrap", vecs[0], vecs[0], -1, 15, 20);
    run_scan("restart_wrap", vecs[0], vecs[0], -1, -1, 20);

    // Asynchronous reset mid-frame darkens immediately, scan restarts from digit 0 via blanking.
    go_idle("pre_reset");
    run_scan("pre_rst", vecs[0], vecs[0], -1, -1, 10);
    #2 reset = 1'b0;
    #1 check_dark("async_reset");
    step();
    check_dark("reset_held");
    reset = 1'b1;
    run_scan("post_rst", vecs[0], vecs[0], -1, -1, 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
